// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and helpers for the fetch sequencer.
package fetch_sequencer_pkg;
    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_HOLD  = 3'd2,
        FS_DRAIN = 3'd3,
        FS_FAULT = 3'd4
    } fetch_state_e;

    function automatic logic is_bus_state(input fetch_state_e s);
        return s == FS_REQ || s == FS_DRAIN;
    endfunction
endpackage

// File: rtl/fetch_timeout.sv
// fetch_timeout: loadable down-counter bounding how long a memory read may wait for its ack.
module fetch_timeout #(
    parameter int Cycles = 15,
    parameter int Width  = $clog2(Cycles + 1)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Load,
    input  logic En,
    output logic Expired
);
    logic [Width-1:0] count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            count <= '0;
        else if (Load)
            count <= Width'(Cycles);
        else if (En && count != '0)
            count <= count - Width'(1);
    end

    // High during the last permitted waiting cycle, so the fault lands on that edge.
    assign Expired = En && count == Width'(1);
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC-driven instruction fetch over a req/ack memory bus into a handshaked IR.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int AddrWidth     = 8,
    parameter int InstrWidth    = 16,
    parameter int TimeoutCycles = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Run,
    input  logic                  Flush,
    input  logic [AddrWidth-1:0]  PcIn,
    output logic                  PcIncN,
    output logic [AddrWidth-1:0]  MemAddr,
    output logic                  MemReq,
    input  logic                  MemAck,
    input  logic [InstrWidth-1:0] MemData,
    output logic [InstrWidth-1:0] IR,
    output logic                  IRValid,
    input  logic                  IRReady,
    output logic                  Busy,
    output logic                  Fault
);
    fetch_state_e state, state_n;
    logic [AddrWidth-1:0] addr_n, next_pc;
    logic [InstrWidth-1:0] ir_n;
    logic req_n, valid_n, inc_n, fault_n, expired, load;

    fetch_timeout #(.Cycles(TimeoutCycles)) u_timeout (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load   (load),
        .En     (is_bus_state(state) && !MemAck),
        .Expired(expired)
    );

    assign load = is_bus_state(state_n) && state_n != state;
    // The PC only steps on the edge closing the strobe cycle, so an accept in that cycle adds one itself.
    assign next_pc = PcIncN ? PcIn : PcIn + AddrWidth'(1);

    always_comb begin
        state_n = state;
        req_n   = MemReq;
        addr_n  = MemAddr;
        ir_n    = IR;
        valid_n = IRValid;
        inc_n   = 1'b1;
        fault_n = Fault;
        case (state)
            FS_IDLE: if (Run && !Flush) begin
                state_n = FS_REQ;
                addr_n  = PcIn;
                req_n   = 1'b1;
            end
            FS_REQ, FS_DRAIN: if (MemAck) begin
                req_n   = 1'b0;
                state_n = FS_IDLE;
                if (state == FS_REQ && !Flush) begin
                    state_n = FS_HOLD;
                    ir_n    = MemData;
                    valid_n = 1'b1;
                    inc_n   = 1'b0;
                end
            end else if (expired) begin
                req_n   = 1'b0;
                fault_n = 1'b1;
                state_n = FS_FAULT;
            end else if (state == FS_REQ && Flush) begin
                state_n = FS_DRAIN;
            end
            FS_HOLD: if (Flush) begin
                valid_n = 1'b0;
                state_n = FS_IDLE;
            end else if (IRReady) begin
                valid_n = 1'b0;
                state_n = Run ? FS_REQ : FS_IDLE;
                req_n   = Run;
                addr_n  = Run ? next_pc : MemAddr;
            end
            FS_FAULT: begin
                req_n   = 1'b0;
                valid_n = 1'b0;
                fault_n = 1'b1;
            end
            default: state_n = FS_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= FS_IDLE;
            PcIncN  <= 1'b1;
            MemReq  <= 1'b0;
            MemAddr <= '0;
            IR      <= '0;
            IRValid <= 1'b0;
            Busy    <= 1'b0;
            Fault   <= 1'b0;
        end else begin
            state   <= state_n;
            PcIncN  <= inc_n;
            MemReq  <= req_n;
            MemAddr <= addr_n;
            IR      <= ir_n;
            IRValid <= valid_n;
            Busy    <= is_bus_state(state_n);
            Fault   <= fault_n;
        end
    end
endmodule
